// File: rtl/uart_pkg.sv
// Shared FSM encodings, parity modes and parity helper for the UART controller.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    localparam int unsigned MAX_DATA_BITS = 9;

    // Callers zero-extend the payload, so unused upper bits do not disturb the XOR.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input int unsigned              mode);
        logic p;
        p = ^data;
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO with first-word fall-through read and registered status.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_empty;
    logic             r_full;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_count_nxt;

    // A pop on empty is ignored; a push into a full FIFO lands only alongside a pop.
    assign w_pop  = i_pop && !r_empty;
    assign w_push = i_push && (!r_full || w_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + (AW+1)'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == FULL_CNT);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty = r_empty;
    assign o_full  = r_full;
    assign o_count = r_count;

endmodule

// File: rtl/uart_mem_ctrl.sv
// UART transceiver: valid/ready TX, synchronised RX into a readable FIFO,
// sticky parity/framing/overrun flags.
module uart_mem_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_rx,
    output logic                        o_tx,
    input  logic [DATA_BITS-1:0]        i_tx_data,
    input  logic                        i_tx_valid,
    output logic                        o_tx_ready,
    output logic                        o_tx_done,
    input  logic                        i_rx_rd_en,
    output logic [DATA_BITS-1:0]        o_rx_rd_data,
    output logic                        o_rx_empty,
    output logic                        o_rx_full,
    output logic [$clog2(FIFO_DEPTH):0] o_rx_count,
    output logic                        o_rx_done,
    output logic                        o_parity_err,
    output logic                        o_frame_err,
    output logic                        o_overrun_err,
    input  logic                        i_err_clr
);

    localparam int unsigned CW         = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int unsigned IW         = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP  = (STOP_BITS == 2);
    localparam logic          HAS_PARITY = (PARITY_MODE != PARITY_NONE);

    // ---------------- Transmitter ----------------
    uart_state_e          r_tx_state;
    logic [CW-1:0]        r_tx_cnt;
    logic [IW-1:0]        r_tx_idx;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx;
    logic                 r_tx_ready;
    logic                 r_tx_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_state <= StIdle;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            unique case (r_tx_state)
                StIdle: begin
                    if (i_tx_valid && r_tx_ready) begin
                        r_tx_shift <= i_tx_data;
                        r_tx_par   <= calc_parity(MAX_DATA_BITS'(i_tx_data), PARITY_MODE);
                        r_tx_cnt   <= '0;
                        r_tx_idx   <= '0;
                        r_tx       <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_tx_state <= StStart;
                    end
                end
                StStart: begin
                    if (r_tx_cnt == BIT_END) begin
                        r_tx_cnt   <= '0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_state <= StData;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                StData: begin
                    if (r_tx_cnt == BIT_END) begin
                        r_tx_cnt <= '0;
                        if (r_tx_idx == LAST_BIT) begin
                            if (HAS_PARITY) begin
                                r_tx       <= r_tx_par;
                                r_tx_state <= StParity;
                            end else begin
                                r_tx       <= 1'b1;
                                r_tx_state <= StStop;
                            end
                        end else begin
                            r_tx_idx   <= r_tx_idx + IW'(1);
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx       <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                StParity: begin
                    if (r_tx_cnt == BIT_END) begin
                        r_tx_cnt   <= '0;
                        r_tx       <= 1'b1;
                        r_tx_state <= StStop;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                StStop: begin
                    // Ready returns with the done pulse so a held tx_valid is taken next edge.
                    if (r_tx_cnt == STOP_END) begin
                        r_tx_cnt   <= '0;
                        r_tx_done  <= 1'b1;
                        r_tx_ready <= 1'b1;
                        r_tx_state <= StIdle;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                default: r_tx_state <= StIdle;
            endcase
        end
    end

    // ---------------- Receiver ----------------
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    uart_state_e          r_rx_state;
    logic [CW-1:0]        r_rx_cnt;
    logic [IW-1:0]        r_rx_idx;
    logic                 r_rx_stop_idx;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun_err;

    logic w_rx_bit_end;
    logic w_par_bad;
    logic w_stop_smp;
    logic w_frame_bad;
    logic w_frame_ok;
    logic w_overrun;
    logic w_fifo_full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_rx_bit_end = (r_rx_cnt == BIT_END);
    assign w_par_bad    = (r_rx_state == StParity) && w_rx_bit_end &&
                          (r_rx_sync != calc_parity(MAX_DATA_BITS'(r_rx_shift), PARITY_MODE));
    assign w_stop_smp   = (r_rx_state == StStop) && w_rx_bit_end;
    assign w_frame_bad  = w_stop_smp && !r_rx_sync;
    assign w_frame_ok   = w_stop_smp && r_rx_sync && (r_rx_stop_idx == LAST_STOP);
    assign w_overrun    = w_frame_ok && w_fifo_full && !i_rx_rd_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_state    <= StIdle;
            r_rx_cnt      <= '0;
            r_rx_idx      <= '0;
            r_rx_stop_idx <= 1'b0;
            r_rx_shift    <= '0;
        end else begin
            unique case (r_rx_state)
                StIdle: begin
                    if (!r_rx_sync) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= StStart;
                    end
                end
                StStart: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (r_rx_cnt == HALF_END) begin
                        r_rx_cnt   <= '0;
                        r_rx_idx   <= '0;
                        r_rx_state <= r_rx_sync ? StIdle : StData;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                StData: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_idx == LAST_BIT) begin
                            r_rx_stop_idx <= 1'b0;
                            r_rx_state    <= HAS_PARITY ? StParity : StStop;
                        end else begin
                            r_rx_idx <= r_rx_idx + IW'(1);
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                StParity: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt      <= '0;
                        r_rx_stop_idx <= 1'b0;
                        r_rx_state    <= StStop;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                StStop: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt <= '0;
                        if (!r_rx_sync) begin
                            r_rx_state <= StBreak;
                        end else if (r_rx_stop_idx == LAST_STOP) begin
                            r_rx_state <= StIdle;
                        end else begin
                            r_rx_stop_idx <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                StBreak: begin
                    if (r_rx_sync) r_rx_state <= StIdle;
                end
                default: r_rx_state <= StIdle;
            endcase
        end
    end

    // Set events take priority over a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_parity_err  <= w_par_bad   | (r_parity_err  & ~i_err_clr);
            r_frame_err   <= w_frame_bad | (r_frame_err   & ~i_err_clr);
            r_overrun_err <= w_overrun   | (r_overrun_err & ~i_err_clr);
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_frame_ok),
        .i_wdata (r_rx_shift),
        .i_pop   (i_rx_rd_en),
        .o_rdata (o_rx_rd_data),
        .o_empty (o_rx_empty),
        .o_full  (w_fifo_full),
        .o_count (o_rx_count)
    );

    assign o_tx          = r_tx;
    assign o_tx_ready    = r_tx_ready;
    assign o_tx_done     = r_tx_done;
    assign o_rx_full     = w_fifo_full;
    assign o_rx_done     = w_frame_ok && !w_overrun;
    assign o_parity_err  = r_parity_err;
    assign o_frame_err   = r_frame_err;
    assign o_overrun_err = r_overrun_err;

endmodule
